// File: rtl/gpi_debounce_evt.sv
// GPI conditioning: synchroniser, per-channel debounce,
// edge pulses and sticky clearable events with one interrupt.
module gpi_debounce_evt #(
  parameter int GpiWidth       = 8,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 50000
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_i,
  input  logic [GpiWidth-1:0] gp_raw_i,
  input  logic [GpiWidth-1:0] rise_en_i,
  input  logic [GpiWidth-1:0] fall_en_i,
  input  logic [GpiWidth-1:0] evt_clr_i,
  output logic [GpiWidth-1:0] gp_o,
  output logic [GpiWidth-1:0] rise_pulse_o,
  output logic [GpiWidth-1:0] fall_pulse_o,
  output logic [GpiWidth-1:0] evt_o,
  output logic                irq_o
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax =
    CntW'(DebounceCycles - 1);

  logic [GpiWidth-1:0] sync_q [SyncStages];
  logic [GpiWidth-1:0] sync;

  logic [CntW-1:0] cnt_q [GpiWidth];
  logic [CntW-1:0] cnt_d [GpiWidth];

  logic [GpiWidth-1:0] acc;
  logic [GpiWidth-1:0] gp_q, gp_d;
  logic [GpiWidth-1:0] rise_q, rise_d;
  logic [GpiWidth-1:0] fall_q, fall_d;
  logic [GpiWidth-1:0] evt_q, evt_d;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= gp_raw_i;
      for (int s = 1; s < SyncStages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SyncStages-1];

  // A mismatch must persist for DebounceCycles samples in a row.
  always_comb begin
    acc = '0;
    for (int i = 0; i < GpiWidth; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != gp_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          acc[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    gp_d   = gp_q ^ acc;
    rise_d = acc & sync;
    fall_d = acc & ~sync;
    // Set dominates clear.
    evt_d  = (rise_q & rise_en_i)
           | (fall_q & fall_en_i)
           | (evt_q & ~evt_clr_i);
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      for (int i = 0; i < GpiWidth; i++) begin
        cnt_q[i] <= '0;
      end
      gp_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
    end else begin
      for (int i = 0; i < GpiWidth; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      gp_q   <= gp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
    end
  end

  assign gp_o         = gp_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
  assign evt_o        = evt_q;
  assign irq_o        = |evt_q;

endmodule
